// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI primary: FSM states, header layout, byte limit.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package spi_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_state_t;

   // Header byte layout: {rw, mb, addr[5:0]}
   localparam int SPI_RW_BIT    = 7;
   localparam int SPI_MB_BIT    = 6;
   localparam int SPI_MAX_BYTES = 8;

   // Data bytes in a frame: single-byte unless multibyte, then 0 -> 1 and >8 -> 8.
   function automatic logic [3:0] resolve_nbytes(input logic multibyte, input logic [3:0] nbytes);
      if (!multibyte || nbytes == 4'd0) return 4'd1;
      if (nbytes > 4'(SPI_MAX_BYTES))   return 4'(SPI_MAX_BYTES);
      return nbytes;
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SPI_CLK half-period timer: one-cycle fall_stb / rise_stb strobes, alternating every CLK_DIV clocks.
// Latency: fall_stb in the first enabled cycle, rise_stb CLK_DIV cycles later, and so on.
// Backpressure: none; dropping en resets it to the fall phase.
// Ports: clk, reset_n, en (run), fall_stb, rise_stb.
module spi_clk_div #(
   parameter int CLK_DIV = 25
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   output logic fall_stb,
   output logic rise_stb
);
   localparam int            CW       = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          ph;     // 0: low half comes next, 1: high half comes next

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         ph  <= 1'b0;
      end else if (!en) begin
         cnt <= '0;
         ph  <= 1'b0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
         ph  <= ~ph;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign fall_stb = en && !ph && (cnt == '0);
   assign rise_stb = en &&  ph && (cnt == '0);

endmodule

// File: rtl/spi_primary.sv
// SPI mode-3 primary: one command -> CSN-framed header byte plus 1..8 data bytes.
// Latency: done CS_SETUP + 16*CLK_DIV*(N+1) + 2*CS_HOLD + 1 clocks from start; rx_valid 1 clock after a byte's last rise.
// Backpressure: start ignored while busy; write bytes pulled via tx_ready, read bytes pushed via rx_valid (no stall).
// Ports: clk/reset_n; command start/read/multibyte/addr/nbytes; tx_data/tx_ready; rx_data/rx_valid;
//        status busy/done; pins SPI_CSN, SPI_CLK, SPI_SDI (out), SPI_SDO (in).
module spi_primary
   import spi_pkg::*;
#(
   parameter int CLK_DIV  = 25,
   parameter int CS_SETUP = 4,
   parameter int CS_HOLD  = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       read,
   input  logic       multibyte,
   input  logic [5:0] addr,
   input  logic [3:0] nbytes,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       done,
   output logic       SPI_CSN,
   output logic       SPI_CLK,
   output logic       SPI_SDI,
   input  logic       SPI_SDO
);
   localparam int             PMAX       = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int             PHW        = $clog2(PMAX) + 1;
   localparam logic [PHW-1:0] SETUP_LAST = PHW'(CS_SETUP - 1);
   localparam logic [PHW-1:0] HOLD_LAST  = PHW'(CS_HOLD - 1);

   spi_state_t     state, state_nxt;
   logic [PHW-1:0] tcnt;
   logic           read_q;
   logic [3:0]     nb_q;
   logic [7:0]     tx_sh, rx_sh, hdr;
   logic [2:0]     bit_cnt;
   logic [3:0]     byte_cnt;
   logic           bits_done;
   logic           csn_q, sclk_q, sdi_q, rx_valid_q, done_q;
   logic [7:0]     rx_data_q;
   logic           fall_stb, rise_stb, div_en, setup_last, load_stb;

   // The divider starts in the last SETUP cycle so the registered SPI_CLK
   // falls exactly CS_SETUP clocks after SPI_CSN.
   assign setup_last = (state == SETUP) && (tcnt == SETUP_LAST);
   assign div_en     = setup_last || (state == SHIFT);

   spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (div_en),
      .fall_stb (fall_stb),
      .rise_stb (rise_stb)
   );

   // 8th rise of a byte that is followed by another data byte
   assign load_stb = (state == SHIFT) && rise_stb && (bit_cnt == 3'd7) && (byte_cnt != nb_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tx_ready  = 1'b0;
      hdr       = '0;
      hdr[SPI_RW_BIT] = read;
      hdr[SPI_MB_BIT] = multibyte;
      hdr[5:0]        = addr;
      case (state)
         IDLE:  if (start) state_nxt = SETUP;
         SETUP: if (tcnt == SETUP_LAST) state_nxt = SHIFT;
         // Leave on the fall that would open bit (N+1)*8, so the last
         // bit keeps its full high half-period.
         SHIFT: begin
            if (fall_stb && bits_done) state_nxt = HOLD;
            tx_ready = load_stb && !read_q;
         end
         HOLD:  if (tcnt == HOLD_LAST) state_nxt = GAP;
         GAP:   if (tcnt == HOLD_LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                tcnt <= '0;
      else if (state_nxt != state) tcnt <= '0;
      else                         tcnt <= tcnt + PHW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         read_q     <= 1'b0;
         nb_q       <= 4'd1;
         tx_sh      <= '0;
         rx_sh      <= '0;
         bit_cnt    <= '0;
         byte_cnt   <= '0;
         bits_done  <= 1'b0;
         csn_q      <= 1'b1;
         sclk_q     <= 1'b1;
         sdi_q      <= 1'b1;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         done_q     <= (state == GAP) && (tcnt == HOLD_LAST);

         if (state == IDLE && start) begin
            read_q    <= read;
            nb_q      <= resolve_nbytes(multibyte, nbytes);
            tx_sh     <= hdr;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            bits_done <= 1'b0;
            csn_q     <= 1'b0;
            sdi_q     <= hdr[7];
         end

         if (fall_stb) begin
            if (bits_done) begin
               sdi_q <= 1'b1;
            end else begin
               sclk_q <= 1'b0;
               sdi_q  <= tx_sh[~bit_cnt];   // MSB first
            end
         end

         if (rise_stb) begin
            sclk_q  <= 1'b1;
            rx_sh   <= {rx_sh[6:0], SPI_SDO};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               // byte_cnt 0 is the header: nothing meaningful comes back
               if (read_q && byte_cnt != 4'd0) begin
                  rx_data_q  <= {rx_sh[6:0], SPI_SDO};
                  rx_valid_q <= 1'b1;
               end
               if (byte_cnt == nb_q) begin
                  bits_done <= 1'b1;
               end else begin
                  byte_cnt <= byte_cnt + 4'd1;
                  tx_sh    <= read_q ? 8'hFF : tx_data;
               end
            end
         end

         if (state == HOLD && tcnt == HOLD_LAST) csn_q <= 1'b1;
      end
   end

   assign busy     = (state != IDLE);
   assign done     = done_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign SPI_CSN  = csn_q;
   assign SPI_CLK  = sclk_q;
   assign SPI_SDI  = sdi_q;

endmodule

// File: doc/spi_primary.md
# spi_primary

Synthesizable SPI primary (controller) for the DE10-Lite accelerometer link, in SPI mode 3 (CPOL=1, CPHA=1). Turns a single-cycle command (read/write, register address, byte count) into one chip-select-framed transaction: header byte, then 1–8 data bytes. Sits between the sensor-polling logic and the board SPI pins. Write data is pulled byte-by-byte; read data is pushed out as valid pulses.

## Interface
- CLK_DIV, 25: system clocks per SPI_CLK half-period (min 2); 50 MHz / 50 = 1 MHz SCLK
- CS_SETUP, 4: clocks between SPI_CSN falling and the first SPI_CLK falling edge (min 1)
- CS_HOLD, 4: clocks SPI_CSN stays low after the last rising edge, and also clocks it stays high before done (min 1)
- clk  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe; accepted only when busy=0
- read  in  1  1 = read frame, 0 = write frame
- multibyte  in  1  header MB bit
- addr  in  6  register address
- nbytes  in  4  data bytes when multibyte=1 (0 treated as 1, >8 clamped to 8); ignored when multibyte=0 (exactly 1)
- tx_data  in  8  write byte, sampled in the tx_ready cycle
- tx_ready  out  1  one-cycle pulse: tx_data consumed
- rx_data  out  8  last received byte
- rx_valid  out  1  one-cycle pulse: rx_data updated
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end
- SPI_CSN  out  1  chip select, active low
- SPI_CLK  out  1  serial clock, idles high
- SPI_SDI  out  1  primary-to-secondary data
- SPI_SDO  in  1  secondary-to-primary data

## Operation
- Reset values: SPI_CSN=1, SPI_CLK=1, SPI_SDI=1, busy=0, done=0, tx_ready=0, rx_valid=0, rx_data=8'h00, state IDLE. Reset mid-frame aborts immediately. No partial rx_valid or done is issued.
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE: start=1 latches read, multibyte, addr and the resolved byte count N. The header is {read, multibyte, addr}. Go to SETUP.
- SETUP: SPI_CSN=0, SPI_SDI = header MSB. Lasts CS_SETUP cycles.
- SHIFT: transfers (N+1)×8 bits, MSB first; the header goes first.
  - Falling edge: SPI_CLK→0 and SPI_SDI updated in the same cycle.
  - Rising edge: after CLK_DIV cycles, SPI_CLK→1 and SPI_SDO is shifted in during that same cycle.
- Write frames:
  - At each data-byte load, tx_ready pulses and tx_data is captured that cycle.
  - The first load happens in the cycle of the header's 8th rising edge.
  - The caller holds tx_data valid while busy and changes it only after tx_ready.
- Read frames: SPI_SDI=1 during data bytes. After each data byte's 8th rising edge, rx_data ← the shifted byte and rx_valid=1 on the next cycle. The header produces no rx_valid.
- HOLD: SPI_CLK=1, SPI_CSN=0 for CS_HOLD cycles. GAP: SPI_CSN=1, SPI_SDI=1 for CS_HOLD cycles.
- done=1 in the first IDLE cycle after GAP. busy=1 in every non-IDLE state.
- start while busy is ignored and not queued. start in the done cycle is accepted.

## Timing
- Bit period 2×CLK_DIV clocks.
- done rises exactly CS_SETUP + 16·CLK_DIV·(N+1) + 2·CS_HOLD + 1 cycles after the start edge.
- rx_valid latency is 1 cycle after the byte's final rising edge.
- Counter widths:
  - divider: $clog2(CLK_DIV)
  - bit counter: 3 bits, wraps 7→0 per byte
  - byte counter: 4 bits, counts 0..N
- SPI_SDO is sampled only in SPI_CLK-rise cycles. It must be stable CLK_DIV−1 cycles before that cycle (secondary changes on the falling edge).

## Structure
- Package spi_pkg:
  - state enum spi_state_t {IDLE, SETUP, SHIFT, HOLD, GAP}
  - header bit positions SPI_RW_BIT=7, SPI_MB_BIT=6
  - SPI_MAX_BYTES=8
- Sub-module spi_clk_div: counts CLK_DIV and emits one-cycle fall_stb/rise_stb while enabled. Restarts at the fall phase when enabled. The FSM and shift registers stay in spi_primary.

## Test plan
- Read addr 0x00 (CLK_DIV=2, CS_SETUP=4, CS_HOLD=4), secondary model returns 0xE5 → header 0x80 on SPI_SDI, one rx_valid with rx_data=0xE5, done 77 cycles after start.
- Write addr 0x2D, tx_data=0x08 → SPI_SDI bytes 0x2D, 0x08; exactly one tx_ready; no rx_valid; SPI_CLK idles high in HOLD.
- Multibyte read addr 0x32, nbytes=6, model returns 0x01..0x06 → header 0xF2, six rx_valid pulses in order 0x01..0x06, then CSN high.
- Multibyte write addr 0x1E, nbytes=3, data 0xAA, 0x55, 0x0F → header 0x5E, three tx_ready pulses, SDI bytes match.
- start pulsed while busy → ignored; frame count and header unchanged.
- reset_n low during the 3rd data bit → all outputs reach reset values in the same cycle. A new read after release completes normally.
